// File: rtl/irq_encoder.sv
// Interrupt request encoder: synchronises four external interrupt lines,
// latches them as pending, and presents the highest-priority eligible source
// to the CPU over a req/ack handshake. In-service tracking ensures a nested
// interrupt preempts only when its priority is strictly higher than the
// highest source currently being serviced.
module irq_encoder #(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TRIG   = 1
) (
  input  logic       in_clk,
  input  logic       in_rst_n,
  input  logic [3:0] in_irq,
  input  logic [3:0] in_mask,
  input  logic       in_ie,
  input  logic       in_ack,
  input  logic       in_eret,
  output logic       out_req,
  output logic [1:0] out_code,
  output logic [3:0] out_pending,
  output logic [3:0] out_inservice
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  // Highest set bit of a 4-bit vector, returned as {found, index}.
  // Source 3 has the highest priority, so the last hit in the loop wins.
  function automatic logic [2:0] top_bit(input logic [3:0] v);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

  // One-hot decode of a source number.
  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] irq_sync;
  logic [3:0] irq_prev;
  logic [3:0] irq_set;

  logic [3:0] pending;
  logic [3:0] inservice;
  logic [0:0] state;
  logic [1:0] code;

  logic [2:0] is_top;
  logic [3:0] allow;
  logic [3:0] eligible;
  logic [2:0] elig_top;
  logic       ack_take;
  logic       withdraw;
  logic [3:0] pend_clr;
  logic [3:0] eret_clr;
  logic [3:0] is_set;
  logic [3:0] pend_next;
  logic [3:0] is_next;
  logic [0:0] state_next;
  logic [1:0] code_next;

  // Synchroniser chain bringing the asynchronous lines into the clock domain.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= in_irq;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign irq_sync = sync_q[SYNC_STAGES-1];

  // Previous synchronised value, used for rising-edge detection.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) irq_prev <= '0;
    else           irq_prev <= irq_sync;
  end

  // Pending-set request: rising edge or level, depending on trigger mode.
  always_comb begin
    irq_set = (EDGE_TRIG != 0) ? (irq_sync & ~irq_prev) : irq_sync;
  end

  // Eligibility: pending, unmasked, globally enabled and strictly above the
  // highest in-service level (anything is allowed when nothing is in service).
  always_comb begin
    is_top = top_bit(inservice);
    allow  = '0;
    for (int i = 0; i < 4; i++) begin
      allow[i] = ~is_top[2] | (2'(i) > is_top[1:0]);
    end
    eligible = pending & ~in_mask & allow & {4{in_ie}};
    elig_top = top_bit(eligible);
  end

  // Handshake outcomes and the resulting pending / in-service updates.
  // A fresh set on the same source as the ack clear wins; eret removes the
  // highest old in-service bit before the acked source is added.
  always_comb begin
    ack_take  = (state == ST_REQ) & in_ack;
    withdraw  = (state == ST_REQ) & ~in_ack & (~in_ie | in_mask[code]);
    pend_clr  = ack_take ? onehot(code) : 4'b0000;
    is_set    = ack_take ? onehot(code) : 4'b0000;
    eret_clr  = (in_eret & is_top[2]) ? onehot(is_top[1:0]) : 4'b0000;
    pend_next = (pending & ~pend_clr) | irq_set;
    is_next   = (inservice & ~eret_clr) | is_set;
  end

  // Request FSM: arbitrate only from IDLE; the code stays frozen while in REQ.
  always_comb begin
    state_next = state;
    code_next  = code;
    if (state == ST_IDLE) begin
      if (elig_top[2]) begin
        state_next = ST_REQ;
        code_next  = elig_top[1:0];
      end
    end else begin
      if (ack_take || withdraw) state_next = ST_IDLE;
    end
  end

  // Pending and in-service registers.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      pending   <= '0;
      inservice <= '0;
    end else begin
      pending   <= pend_next;
      inservice <= is_next;
    end
  end

  // FSM state and latched source code.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state <= ST_IDLE;
      code  <= 2'b00;
    end else begin
      state <= state_next;
      code  <= code_next;
    end
  end

  assign out_req       = (state == ST_REQ);
  assign out_code      = code;
  assign out_pending   = pending;
  assign out_inservice = inservice;

endmodule

// File: tb/tb_irq_encoder.sv
// Testbench for irq_encoder: directed scenarios followed by random traffic,
// checked against a behavioural model through a request-code scoreboard.
module tb_irq_encoder;

  localparam int S = 2;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] d_irq, d_mask;
  logic       d_ie, d_ack, d_eret;
  logic [3:0] irq_lvl;

  logic       n_rst, n_ie;
  logic [3:0] n_mask, n_lvl;

  logic       out_req;
  logic [1:0] out_code;
  logic [3:0] out_pending, out_inservice;

  logic       lvl_req;
  logic [1:0] lvl_code;
  logic [3:0] lvl_pending, lvl_inservice;

  irq_encoder #(.SYNC_STAGES(S), .EDGE_TRIG(1)) dut (
    .in_clk(clk), .in_rst_n(rst_n), .in_irq(d_irq), .in_mask(d_mask),
    .in_ie(d_ie), .in_ack(d_ack), .in_eret(d_eret),
    .out_req(out_req), .out_code(out_code),
    .out_pending(out_pending), .out_inservice(out_inservice)
  );

  irq_encoder #(.SYNC_STAGES(S), .EDGE_TRIG(0)) dut_lvl (
    .in_clk(clk), .in_rst_n(rst_n), .in_irq(irq_lvl), .in_mask(4'b0000),
    .in_ie(1'b1), .in_ack(1'b0), .in_eret(1'b0),
    .out_req(lvl_req), .out_code(lvl_code),
    .out_pending(lvl_pending), .out_inservice(lvl_inservice)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [3:0] m_hist[$];   // raw line samples, index k = sampled k edges ago
  logic [3:0] m_pend, m_is;
  logic       m_req;
  int         m_code;
  int         exp_q[$];    // expected request codes, in order

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_hist = {};
    for (int k = 0; k < S + 2; k++) m_hist.push_back(4'b0000);
    m_pend = 4'b0000;
    m_is   = 4'b0000;
    m_req  = 1'b0;
    m_code = 0;
  endtask

  // Advance the model across one rising edge using the inputs applied for it.
  task automatic model_step();
    int top;
    int best;
    logic [3:0] np, ns;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_hist.push_front(d_irq);
    void'(m_hist.pop_back());
    top = -1;
    for (int i = 3; i >= 0; i--) if (top < 0 && m_is[i]) top = i;
    np = m_pend;
    ns = m_is;
    if (d_eret && top >= 0) ns[top] = 1'b0;
    if (m_req) begin
      if (d_ack) begin
        np[m_code] = 1'b0;
        ns[m_code] = 1'b1;
        m_req = 1'b0;
      end else if (!d_ie || d_mask[m_code]) begin
        m_req = 1'b0;
      end
    end else begin
      best = -1;
      for (int i = 3; i >= 0; i--)
        if (best < 0 && m_pend[i] && !d_mask[i] && d_ie && i > top) best = i;
      if (best >= 0) begin
        m_req  = 1'b1;
        m_code = best;
        exp_q.push_back(best);
      end
    end
    for (int i = 0; i < 4; i++)
      if (m_hist[S][i] && !m_hist[S+1][i]) np[i] = 1'b1;
    m_pend = np;
    m_is   = ns;
  endtask

  // Apply one cycle of stimulus at the falling edge and advance the model.
  task automatic step(input logic [3:0] irq, input logic ack, input logic eret);
    @(negedge clk);
    rst_n   = n_rst;
    d_irq   = irq;
    d_ack   = ack;
    d_eret  = eret;
    d_mask  = n_mask;
    d_ie    = n_ie;
    irq_lvl = n_lvl;
    model_step();
  endtask

  task automatic idle(input int n);
    repeat (n) step(4'b0000, 1'b0, 1'b0);
  endtask

  task automatic look();
    @(posedge clk);
    #2;
  endtask

  // Monitor: compares registers every cycle and pops the scoreboard on each new request.
  initial begin : monitor
    logic prev_req;
    int   e;
    prev_req = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      chk("req", out_req, m_req);
      chk("pend", out_pending, m_pend);
      chk("insvc", out_inservice, m_is);
      if (out_req === 1'b1 && prev_req !== 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL code_q: request with code %0d but none expected", out_code);
        end else begin
          e = exp_q.pop_front();
          chk("code", out_code, e);
        end
      end
      prev_req = out_req;
    end
  end

  initial begin : stimulus
    logic [3:0] cur_irq;
    logic [3:0] flip;
    n_rst = 1'b0; n_mask = 4'b0000; n_ie = 1'b1; n_lvl = 4'b0000;
    d_irq = 4'b0000; d_mask = 4'b0000; d_ie = 1'b1; d_ack = 1'b0; d_eret = 1'b0;
    irq_lvl = 4'b0000;
    rst_n = 1'b1;
    model_reset();
    #2 rst_n = 1'b0;
    idle(2);
    chk("rst_req", out_req, 1'b0);
    chk("rst_code", out_code, 2'b00);
    chk("rst_pend", out_pending, 4'b0000);
    chk("rst_insvc", out_inservice, 4'b0000);
    chk("rst_lvl_pend", lvl_pending, 4'b0000);
    n_rst = 1'b1;
    idle(3);

    // Single source, latency and ack
    step(4'b0010, 1'b0, 1'b0);
    idle(2);
    look();
    chk("t1_pend_n2", out_pending, 4'b0010);
    chk("t1_req_n2", out_req, 1'b0);
    idle(1);
    look();
    chk("t1_req_n3", out_req, 1'b1);
    chk("t1_code", out_code, 2'b01);
    step(4'b0000, 1'b1, 1'b0);
    look();
    chk("t1_pend_ack", out_pending, 4'b0000);
    chk("t1_insvc_ack", out_inservice, 4'b0010);
    chk("t1_req_ack", out_req, 1'b0);
    step(4'b0000, 1'b0, 1'b1);
    look();
    chk("t1_insvc_eret", out_inservice, 4'b0000);

    // Two simultaneous sources: priority, then the lower one after eret
    step(4'b1010, 1'b0, 1'b0);
    idle(3);
    look();
    chk("t2_code_hi", out_code, 2'b11);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b1);
    idle(1);
    look();
    chk("t2_req_lo", out_req, 1'b1);
    chk("t2_code_lo", out_code, 2'b01);
    step(4'b0000, 1'b1, 1'b0);

    // Nesting with source 1 in service
    step(4'b0100, 1'b0, 1'b0);
    idle(3);
    look();
    chk("t3_req_nest", out_req, 1'b1);
    chk("t3_code_nest", out_code, 2'b10);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0001, 1'b0, 1'b0);
    idle(5);
    look();
    chk("t3_req_blocked", out_req, 1'b0);
    chk("t3_pend_blocked", out_pending, 4'b0001);
    chk("t3_insvc_two", out_inservice, 4'b0110);
    step(4'b0000, 1'b0, 1'b1);
    idle(3);
    look();
    chk("t3_req_one_eret", out_req, 1'b0);
    step(4'b0000, 1'b0, 1'b1);
    idle(1);
    look();
    chk("t3_req_two_eret", out_req, 1'b1);
    chk("t3_code_low", out_code, 2'b00);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b1);

    // Masked source stays pending until unmasked
    n_mask = 4'b0100;
    step(4'b0100, 1'b0, 1'b0);
    idle(4);
    look();
    chk("t4_pend_masked", out_pending, 4'b0100);
    chk("t4_req_masked", out_req, 1'b0);
    n_mask = 4'b0000;
    idle(1);
    look();
    chk("t4_req_unmask", out_req, 1'b1);
    chk("t4_code_unmask", out_code, 2'b10);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b1);

    // Withdraw on ie drop, re-request on ie rise; level DUT sees a held line
    n_lvl = 4'b0100;
    step(4'b0010, 1'b0, 1'b0);
    idle(3);
    look();
    chk("t5_code", out_code, 2'b01);
    n_ie = 1'b0;
    idle(1);
    look();
    chk("t5_req_withdraw", out_req, 1'b0);
    chk("t5_pend_kept", out_pending, 4'b0010);
    n_ie = 1'b1;
    idle(1);
    look();
    chk("t5_req_again", out_req, 1'b1);
    chk("t5_code_again", out_code, 2'b01);
    chk("t6_lvl_req_pre", lvl_req, 1'b1);
    chk("t6_lvl_code_pre", lvl_code, 2'b10);

    // Asynchronous reset in the middle of a request
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    n_rst = 1'b0;
    model_reset();
    #1;
    chk("t6_req_async", out_req, 1'b0);
    chk("t6_pend_async", out_pending, 4'b0000);
    chk("t6_insvc_async", out_inservice, 4'b0000);
    chk("t6_lvl_req_async", lvl_req, 1'b0);
    chk("t6_lvl_pend_async", lvl_pending, 4'b0000);
    idle(2);
    n_rst = 1'b1;
    idle(4);
    look();
    chk("t6_lvl_pend_again", lvl_pending, 4'b0100);
    chk("t6_lvl_req_again", lvl_req, 1'b1);
    chk("t6_lvl_code_again", lvl_code, 2'b10);
    n_lvl = 4'b0000;
    idle(3);

    // Random traffic
    cur_irq = 4'b0000;
    for (int c = 0; c < 3000; c++) begin
      flip = 4'b0000;
      for (int b = 0; b < 4; b++) flip[b] = ($urandom_range(0, 5) == 0);
      cur_irq = cur_irq ^ flip;
      if ($urandom_range(0, 39) == 0)
        n_mask = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      n_ie = ($urandom_range(0, 11) != 0);
      step(cur_irq, m_req && ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0));
    end
    n_mask = 4'b0000;
    n_ie = 1'b1;
    idle(5);
    look();
    chk("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
